// File: rtl/vaddsub_seq_pkg.sv
// rtl/vaddsub_seq_pkg.sv - shared types, encodings and helpers for the vector add/sub sequencer
package vaddsub_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam int MAX_VLEN = 4096;

  localparam logic [1:0] SEW_E8  = 2'b00;
  localparam logic [1:0] SEW_E16 = 2'b01;
  localparam logic [1:0] SEW_E32 = 2'b10;
  localparam logic [1:0] SEW_ILL = 2'b11;

  localparam logic [1:0] LMUL_M1 = 2'b00;
  localparam logic [1:0] LMUL_M2 = 2'b01;
  localparam logic [1:0] LMUL_M4 = 2'b10;
  localparam logic [1:0] LMUL_M8 = 2'b11;

  // Number of registers in the group: 1, 2, 4 or 8.
  function automatic logic [3:0] lmul_to_nregs(input logic [1:0] lmul);
    return 4'd1 << lmul;
  endfunction

  // Adder lane controls packed as {sew_16_32, sew_32}.
  function automatic logic [1:0] sew_to_adder_ctrl(input logic [1:0] sew);
    logic [1:0] ctrl;
    case (sew)
      SEW_E16: ctrl = 2'b10;
      SEW_E32: ctrl = 2'b11;
      default: ctrl = 2'b00;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/vec_addsub_sequencer.sv
// rtl/vec_addsub_sequencer.sv - sequences one vadd/vsub over an LMUL register group (optional VADDSUB_PERF_CNT_EN)
module vec_addsub_sequencer
  import vaddsub_seq_pkg::*;
#(
  parameter int VLEN       = 512,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_sub,
  input  logic [1:0]            req_sew,
  input  logic [1:0]            req_lmul,
  input  logic [REG_ADDR_W-1:0] req_vs1,
  input  logic [REG_ADDR_W-1:0] req_vs2,
  input  logic [REG_ADDR_W-1:0] req_vd,
  output logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [REG_ADDR_W-1:0] rd_addr_b,
  input  logic [VLEN-1:0]       rd_data_a,
  input  logic [VLEN-1:0]       rd_data_b,
  output logic                  add_ctrl,
  output logic                  add_sew_16_32,
  output logic                  add_sew_32,
  output logic [VLEN-1:0]       add_a,
  output logic [VLEN-1:0]       add_b,
  input  logic [VLEN-1:0]       add_sum,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [VLEN-1:0]       wr_data,
  output logic                  busy,
  output logic                  done,
`ifdef VADDSUB_PERF_CNT_EN
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_busy_cycles,
`endif
  output logic                  err_illegal
);

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic                  r_sub;
  logic [1:0]            r_sew;
  logic [1:0]            r_lmul;
  logic [REG_ADDR_W-1:0] r_vs1;
  logic [REG_ADDR_W-1:0] r_vs2;
  logic [REG_ADDR_W-1:0] r_vd;
  logic [VLEN-1:0]       r_result;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_last;
  logic [REG_ADDR_W-1:0] w_mask;
  logic [1:0]            w_sew_ctrl;

  // A group base must be aligned to the group size; the mask exposes the low bits that must be zero.
  assign w_mask     = REG_ADDR_W'(lmul_to_nregs(req_lmul) - 4'd1);
  assign w_legal    = (req_sew != SEW_ILL) &&
                      ((req_vs1 & w_mask) == '0) &&
                      ((req_vs2 & w_mask) == '0) &&
                      ((req_vd  & w_mask) == '0);
  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_last     = ({1'b0, r_cnt} == (lmul_to_nregs(r_lmul) - 4'd1));
  assign w_sew_ctrl = sew_to_adder_ctrl(r_sew);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: read, execute, write once per register in the group.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_legal ? READ : ERR;
      READ:    w_next = EXEC;
      EXEC:    w_next = WRITE;
      WRITE:   w_next = w_last ? IDLE : READ;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, chunk counter and captured adder result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_sub    <= 1'b0;
      r_sew    <= SEW_E8;
      r_lmul   <= LMUL_M1;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_vd     <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_cnt  <= '0;
        r_sub  <= req_sub;
        r_sew  <= req_sew;
        r_lmul <= req_lmul;
        r_vs1  <= req_vs1;
        r_vs2  <= req_vs2;
        r_vd   <= req_vd;
      end
      if (r_state == EXEC) r_result <= add_sum;
      if (r_state == WRITE && !w_last) r_cnt <= r_cnt + 3'd1;
    end
  end

  // Outputs decoded from state; everything idles at zero outside its own phase.
  always_comb begin
    req_ready     = (r_state == IDLE) && reset_n;
    busy          = 1'b0;
    done          = 1'b0;
    err_illegal   = 1'b0;
    rd_addr_a     = '0;
    rd_addr_b     = '0;
    add_ctrl      = 1'b0;
    add_sew_16_32 = 1'b0;
    add_sew_32    = 1'b0;
    add_a         = '0;
    add_b         = '0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    if (r_state == READ || r_state == EXEC || r_state == WRITE) begin
      busy          = 1'b1;
      add_ctrl      = r_sub;
      add_sew_16_32 = w_sew_ctrl[1];
      add_sew_32    = w_sew_ctrl[0];
    end
    case (r_state)
      READ: begin
        rd_addr_a = r_vs2 + REG_ADDR_W'(r_cnt);
        rd_addr_b = r_vs1 + REG_ADDR_W'(r_cnt);
      end
      EXEC: begin
        add_a = rd_data_a;
        add_b = rd_data_b;
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = r_vd + REG_ADDR_W'(r_cnt);
        wr_data = r_result;
        done    = w_last;
      end
      ERR:     err_illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef VADDSUB_PERF_CNT_EN
  // Saturating counters of completed instructions and busy cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops         <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (done && perf_ops != 32'hFFFF_FFFF)         perf_ops         <= perf_ops + 32'd1;
      if (busy && perf_busy_cycles != 32'hFFFF_FFFF) perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_addsub_sequencer.sv
// tb/tb_vec_addsub_sequencer.sv - directed self-checking bench for vec_addsub_sequencer
module tb_vec_addsub_sequencer;
  localparam int VLEN = 512;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_sub = 1'b0;
  logic [1:0]      req_sew = 2'b00;
  logic [1:0]      req_lmul = 2'b00;
  logic [AW-1:0]   req_vs1 = '0, req_vs2 = '0, req_vd = '0;
  logic [AW-1:0]   rd_addr_a, rd_addr_b;
  logic [VLEN-1:0] rd_data_a = '0, rd_data_b = '0;
  logic            add_ctrl, add_sew_16_32, add_sew_32;
  logic [VLEN-1:0] add_a, add_b, add_sum;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [VLEN-1:0] wr_data;
  logic            busy, done, err_illegal;

  vec_addsub_sequencer #(.VLEN(VLEN), .REG_ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_sew(req_sew), .req_lmul(req_lmul),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .add_ctrl(add_ctrl), .add_sew_16_32(add_sew_16_32), .add_sew_32(add_sew_32),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  logic [VLEN-1:0] mem [32];

  // Register file read port: data one cycle after the address.
  always @(posedge clk) begin
    rd_data_a <= mem[rd_addr_a];
    rd_data_b <= mem[rd_addr_b];
  end

  // Lane-wise adder/subtractor standing in for the external datapath.
  always_comb begin
    add_sum = '0;
    if (add_sew_32) begin
      for (int i = 0; i < VLEN / 32; i++)
        add_sum[i*32 +: 32] = add_ctrl ? add_a[i*32 +: 32] - add_b[i*32 +: 32] : add_a[i*32 +: 32] + add_b[i*32 +: 32];
    end else if (add_sew_16_32) begin
      for (int i = 0; i < VLEN / 16; i++)
        add_sum[i*16 +: 16] = add_ctrl ? add_a[i*16 +: 16] - add_b[i*16 +: 16] : add_a[i*16 +: 16] + add_b[i*16 +: 16];
    end else begin
      for (int i = 0; i < VLEN / 8; i++)
        add_sum[i*8 +: 8] = add_ctrl ? add_a[i*8 +: 8] - add_b[i*8 +: 8] : add_a[i*8 +: 8] + add_b[i*8 +: 8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  int              n_wr, done_cyc, err_cyc;
  logic [AW-1:0]   wr_addr_log [16];
  logic [VLEN-1:0] wr_data_log [16];
  logic            busy_or, rd_nz, ctrl_and, ctrl_or, s1632_or, s32_or, s1632_and, s32_and, ready_or;

  task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    n_wr = 0; done_cyc = 0; err_cyc = 0;
    busy_or = 0; rd_nz = 0; ctrl_and = 1; ctrl_or = 0;
    s1632_or = 0; s32_or = 0; s1632_and = 1; s32_and = 1; ready_or = 0;
  endtask

  // Record one negedge sample; committed writes update the register-file model.
  task automatic sample(input int k);
    if (wr_en) begin
      if (n_wr < 16) begin
        wr_addr_log[n_wr] = wr_addr;
        wr_data_log[n_wr] = wr_data;
      end
      mem[wr_addr] = wr_data;
      n_wr++;
    end
    busy_or  |= busy;
    rd_nz    |= (rd_addr_a != '0) || (rd_addr_b != '0);
    ready_or |= req_ready;
    ctrl_or  |= add_ctrl;
    s1632_or |= add_sew_16_32;
    s32_or   |= add_sew_32;
    if (busy) begin
      ctrl_and  &= add_ctrl;
      s1632_and &= add_sew_16_32;
      s32_and   &= add_sew_32;
    end
    if (err_illegal && err_cyc == 0) err_cyc = k;
    if (done && done_cyc == 0) done_cyc = k;
  endtask

  task automatic run(input int budget);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      sample(k);
      if (done_cyc != 0 || err_cyc != 0) break;
    end
  endtask

  // Present a request for one edge, then scramble the fields to prove they were latched.
  task automatic issue(input string tag, input logic sub, input logic [1:0] sew, input logic [1:0] lmul,
                       input logic [AW-1:0] vs1, input logic [AW-1:0] vs2, input logic [AW-1:0] vd);
    @(negedge clk);
    req_sub = sub; req_sew = sew; req_lmul = lmul;
    req_vs1 = vs1; req_vs2 = vs2; req_vd = vd;
    req_valid = 1'b1;
    chk({tag, "_ready"}, VLEN'(req_ready), VLEN'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_sub = ~sub; req_sew = 2'b11; req_lmul = 2'b11;
    req_vs1 = '1; req_vs2 = '1; req_vd = '1;
    clear_log();
  endtask

  logic [VLEN-1:0] exp1, exp2, expb;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < VLEN / 8; i++) mem[1][i*8 +: 8] = 8'h01;
    mem[2][63:0] = 64'h0807060504030201;
    for (int i = 8; i < 12; i++) mem[i][31:0] = 32'd8;
    for (int i = 4; i < 8; i++)  mem[i][31:0] = 32'd2;
    for (int i = 0; i < VLEN / 8; i++) begin
      exp1[i*8 +: 8] = 8'h01;
      expb[i*8 +: 8] = 8'h02;
    end
    exp1[63:0] = 64'h0908070605040302;
    expb[63:0] = 64'h0A09080706050403;
    exp2 = VLEN'(6);

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_ready", VLEN'(req_ready), VLEN'(0));
    chk("rst_busy", VLEN'({busy, done, err_illegal, wr_en}), VLEN'(0));
    reset_n = 1'b1;
    #1;
    chk("rst_ready_out", VLEN'(req_ready), VLEN'(1));

    // e8 vadd m1: vs2=2, vs1=1, vd=3
    issue("t1", 1'b0, 2'b00, 2'b00, 5'd1, 5'd2, 5'd3);
    run(10);
    chk("t1_done_cyc", VLEN'(done_cyc), VLEN'(3));
    chk("t1_n_wr", VLEN'(n_wr), VLEN'(1));
    chk("t1_wr_addr", VLEN'(wr_addr_log[0]), VLEN'(3));
    chk("t1_wr_data", wr_data_log[0], exp1);
    chk("t1_sew_bits", VLEN'({s1632_or, s32_or, ctrl_or}), VLEN'(0));

    // e32 vsub m4: vs2=8, vs1=4, vd=12
    issue("t2", 1'b1, 2'b10, 2'b10, 5'd4, 5'd8, 5'd12);
    run(20);
    chk("t2_done_cyc", VLEN'(done_cyc), VLEN'(12));
    chk("t2_n_wr", VLEN'(n_wr), VLEN'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_wr_addr%0d", i), VLEN'(wr_addr_log[i]), VLEN'(12 + i));
      chk($sformatf("t2_wr_data%0d", i), wr_data_log[i], exp2);
    end
    chk("t2_ctrl_held", VLEN'({ctrl_and, s1632_and, s32_and}), VLEN'(3'b111));

    // e16 vadd m2 with misaligned vd
    issue("t3", 1'b0, 2'b01, 2'b01, 5'd2, 5'd4, 5'd5);
    run(4);
    chk("t3_err_cyc", VLEN'(err_cyc), VLEN'(1));
    chk("t3_no_wr_busy", VLEN'({n_wr != 0, busy_or}), VLEN'(0));
    @(negedge clk);
    chk("t3_ready_again", VLEN'({req_ready, err_illegal}), VLEN'(2'b10));

    // Illegal SEW
    issue("t4", 1'b0, 2'b11, 2'b00, 5'd3, 5'd5, 5'd7);
    run(4);
    chk("t4_err_cyc", VLEN'(err_cyc), VLEN'(1));
    chk("t4_no_rd_wr", VLEN'({rd_nz, n_wr != 0, busy_or}), VLEN'(0));
    @(negedge clk);
    chk("t4_ready_again", VLEN'(req_ready), VLEN'(1));

    // Back-to-back with req_valid held high
    @(negedge clk);
    req_sub = 1'b0; req_sew = 2'b00; req_lmul = 2'b00;
    req_vs1 = 5'd1; req_vs2 = 5'd2; req_vd = 5'd3;
    req_valid = 1'b1;
    chk("b2b_ready0", VLEN'(req_ready), VLEN'(1));
    clear_log();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      sample(k);
    end
    chk("b2b_done1", VLEN'(done_cyc), VLEN'(3));
    chk("b2b_ready_busy", VLEN'(ready_or), VLEN'(0));
    req_sew = 2'b01; req_vs1 = 5'd1; req_vs2 = 5'd3; req_vd = 5'd4;
    @(negedge clk);
    chk("b2b_ready_after", VLEN'(req_ready), VLEN'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    clear_log();
    run(10);
    chk("b2b_done2", VLEN'(done_cyc), VLEN'(3));
    chk("b2b_wr_addr", VLEN'(wr_addr_log[0]), VLEN'(4));
    chk("b2b_wr_data", wr_data_log[0], expb);

    // e8 vadd m8 aborted by reset in the third WRITE
    issue("t5", 1'b0, 2'b00, 2'b11, 5'd8, 5'd0, 5'd0);
    run(8);
    @(negedge clk);
    chk("t5_in_write", VLEN'(wr_en), VLEN'(1));
    reset_n = 1'b0;
    #1;
    chk("t5_abort_out", VLEN'({wr_en, busy, done, req_ready, rd_addr_a, wr_addr}), VLEN'(0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      sample(k);
    end
    reset_n = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      sample(k);
    end
    chk("t5_writes", VLEN'(n_wr), VLEN'(2));
    chk("t5_no_done", VLEN'({done_cyc != 0, busy}), VLEN'(0));
    chk("t5_ready", VLEN'(req_ready), VLEN'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_addsub_sequencer.md
Name: vec_addsub_sequencer

Overview:
- Sequences one vector add/sub instruction across an LMUL register group (1, 2, 4 or 8 registers).
- Per register: issues vector register-file reads, drives the shared combinational `vector_adder_subtractor` (Ctrl, sew_16_32, sew_32, A, B), captures Sum and writes it back.
- Sits between the vector decode/issue stage and the register file / adder datapath.
- Group size VLEN×LMUL ≤ `MAX_VLEN` (512×8 = 4096).

Parameters:
- VLEN, 512, bits per vector register; the adder instance is VLEN wide.
- REG_ADDR_W, 5, vector register index width (32 registers).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  instruction request
- req_ready  out  1  sequencer can accept a request
- req_sub  in  1  0 = vadd, 1 = vsub (vd = vs2 − vs1)
- req_sew  in  2  00 = e8, 01 = e16, 10 = e32, 11 = illegal
- req_lmul  in  2  00 = m1, 01 = m2, 10 = m4, 11 = m8
- req_vs1, req_vs2, req_vd  in  REG_ADDR_W each  base register indices
- rd_addr_a, rd_addr_b  out  REG_ADDR_W  read addresses (a = vs2, b = vs1)
- rd_data_a, rd_data_b  in  VLEN  read data, valid exactly 1 cycle after the address
- add_ctrl, add_sew_16_32, add_sew_32  out  1  adder controls
- add_a, add_b  out  VLEN  adder operands
- add_sum  in  VLEN  adder result (combinational)
- wr_en  out  1  register-file write strobe
- wr_addr  out  REG_ADDR_W  write address
- wr_data  out  VLEN  write data
- busy  out  1  instruction in progress
- done  out  1  1-cycle pulse, instruction complete
- err_illegal  out  1  1-cycle pulse, request rejected

Behaviour:
- Reset (asynchronous, reset_n low):
  - State → IDLE.
  - Every output is 0, except req_ready = 1 once out of reset.
  - Reset asserted mid-instruction aborts it immediately: no further wr_en, no done.
- Handshake:
  - Request is accepted on a rising edge when req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - At acceptance, all req_* fields are registered; later input changes are ignored.
- Legality check (combinational, evaluated at acceptance):
  - Illegal if req_sew == 11, or if any of vs1/vs2/vd is not a multiple of NREGS = 1 << req_lmul.
  - Illegal request → state ERR for 1 cycle: err_illegal = 1, no reads, no writes → IDLE.
- States: IDLE, READ, EXEC, WRITE, ERR.
  - IDLE → READ: legal request accepted; chunk counter cnt = 0.
  - READ: rd_addr_a = vs2 + cnt, rd_addr_b = vs1 + cnt → EXEC.
  - EXEC:
    - add_a = rd_data_a, add_b = rd_data_b.
    - add_sum is registered into a result register → WRITE.
  - WRITE:
    - wr_en = 1, wr_addr = vd + cnt, wr_data = result.
    - If cnt == NREGS−1: done = 1 in the same cycle → IDLE.
    - Otherwise cnt++ → READ.
- Latency:
  - 3 cycles per register; done occurs 3×NREGS cycles after acceptance.
  - Next request can be accepted the cycle after done.
- Adder controls:
  - add_ctrl = latched req_sub.
  - e8 → (sew_16_32 = 0, sew_32 = 0); e16 → (1, 0); e32 → (1, 1).
  - Held constant for the whole instruction; 0 in IDLE.
  - add_a / add_b are 0 outside EXEC.
- busy = 1 in READ, EXEC and WRITE.
- rd_addr_* are 0 outside READ; wr_* are 0 outside WRITE.
- Overlap: vd may equal vs1 or vs2. This is safe because each chunk is read before it is written and chunks are disjoint.
- No wrap-around: alignment guarantees base + NREGS − 1 ≤ 31.

Optional Feature:
- Macro: VADDSUB_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_ops (32 bits) and perf_busy_cycles (32 bits).
  - perf_ops increments on each done; perf_busy_cycles increments on each cycle with busy = 1.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package vaddsub_seq_pkg holds:
  - state enum {IDLE, READ, EXEC, WRITE, ERR};
  - SEW encodings SEW_E8 / SEW_E16 / SEW_E32;
  - LMUL encodings;
  - function lmul_to_nregs();
  - function sew_to_adder_ctrl() returning {sew_16_32, sew_32}.
- No internal sub-module is needed. The `vector_adder_subtractor` is instantiated beside this block, not inside it.

Test Plan:
- e8 vadd, m1, vs2 = 2, vs1 = 1, vd = 3; reg2 bytes 0x01..0x08, reg1 all 0x01.
  → single write to reg3 with bytes 0x02..0x09; done 3 cycles after acceptance; add_sew_16_32 = 0, add_sew_32 = 0.
- e32 vsub, m4, vs2 = 8, vs1 = 4, vd = 12; word0 of each source reg = 8 and 2.
  → writes to regs 12, 13, 14, 15 in order, word0 = 6 each; done at cycle 12; add_ctrl = 1 throughout.
- e16 vadd, m2, vd = 5 (misaligned).
  → err_illegal pulse, no wr_en, req_ready = 1 again the next cycle.
- req_sew = 11, m1.
  → err_illegal pulse, no reads or writes.
- e8 vadd, m8, vs2 = vd = 0, vs1 = 8.
  → reset_n pulled low during the 3rd WRITE: outputs 0 immediately, only 2 writes were ever issued, no done.
- Back-to-back: req_valid held high with two m1 requests.
  → second accepted the cycle after the first done; req_ready low while busy.
